rv_issue_ctrl: RTL and testbench

//  In-order issue controller between the instruction fetch buffer and the execute stage.
//  - Classifies each RV32I instruction by opcode, using the shared opcode constants.
//  - Stalls on load-use hazards using a per-register busy scoreboard.
//  - Bounds the number of outstanding loads.
//  - Serialises control flow: after a branch or jump, it waits for resolution and flushes on taken.

---
 rtl/rv_issue_ctrl_pkg.sv | 35 +++
 rtl/rv_opclass_decode.sv | 42 ++++
 rtl/rv_issue_ctrl.sv | 138 +++++++++++++
 tb/tb_rv_issue_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_issue_ctrl_pkg.sv
// Shared definitions for the RV32I issue controller.
//   - RV32I major opcode constants used by the decoder.
//   - instr_class_t : issue class of an instruction, carried with it into the issue slot.
//   - issue_state_t : control-flow serialisation state of the issue controller.
//   - uses_rs1 / uses_rs2 : which source registers a class reads.
package rv_issue_ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        C_R, C_I, C_IL, C_S, C_SB, C_J, C_JALR, C_LUI, C_AUIPC, C_ILL
    } instr_class_t;

    typedef enum logic [1:0] {
        RUN, BR_WAIT, FLUSH
    } issue_state_t;

    function automatic logic uses_rs1(instr_class_t c);
        return (c == C_R) || (c == C_S) || (c == C_SB) ||
               (c == C_I) || (c == C_IL) || (c == C_JALR);
    endfunction

    function automatic logic uses_rs2(instr_class_t c);
        return (c == C_R) || (c == C_S) || (c == C_SB);
    endfunction

endpackage

// File: rtl/rv_opclass_decode.sv
// Purely combinational opcode classifier for RV32I.
//   instr   in  32  raw instruction
//   cls     out 4   issue class (C_ILL for any unknown opcode)
//   rs1/rs2 out 5   source register fields
//   rd      out 5   destination register field
//   use_rs1 out 1   class reads rs1
//   use_rs2 out 1   class reads rs2
module rv_opclass_decode
    import rv_issue_ctrl_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_t cls,
    output logic [4:0]   rs1,
    output logic [4:0]   rs2,
    output logic [4:0]   rd,
    output logic         use_rs1,
    output logic         use_rs2
);

    always_comb begin
        cls = C_ILL;
        case (instr[6:0])
            OPC_OP:     cls = C_R;
            OPC_OP_IMM: cls = C_I;
            OPC_LOAD:   cls = C_IL;
            OPC_STORE:  cls = C_S;
            OPC_BRANCH: cls = C_SB;
            OPC_JAL:    cls = C_J;
            OPC_JALR:   cls = C_JALR;
            OPC_LUI:    cls = C_LUI;
            OPC_AUIPC:  cls = C_AUIPC;
            default:    cls = C_ILL;
        endcase
    end

    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign rd      = instr[11:7];
    assign use_rs1 = uses_rs1(cls);
    assign use_rs2 = uses_rs2(cls);

endmodule

// File: rtl/rv_issue_ctrl.sv
// In-order issue controller between the fetch buffer and the execute stage.
//   CLK, RES_N            clock (rising edge), asynchronous active-low reset
//   in_valid_i/ready_o    fetch handshake; in_instr_i is the raw instruction
//   iss_valid_o/ready_i   single-entry issue slot handshake; iss_instr_o, iss_class_o
//   ld_done_i, ld_rd_i    load writeback: clears busy[ld_rd_i], retires one load
//   br_resolve_i/taken_i  branch/jump outcome, honoured only in BR_WAIT
//   flush_o               one-cycle pulse after a taken branch/jump
//   illegal_o             one-cycle pulse after an unknown opcode was consumed
//   busy_o                per-register pending-load scoreboard (bit 0 always 0)
//   stall_cnt_o           saturating count of cycles with in_valid_i && !in_ready_o
module rv_issue_ctrl
    import rv_issue_ctrl_pkg::*;
#(
    parameter int unsigned MAX_LD = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             RES_N,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_instr_i,
    output logic             iss_valid_o,
    input  logic             iss_ready_i,
    output logic [31:0]      iss_instr_o,
    output instr_class_t     iss_class_o,
    input  logic             ld_done_i,
    input  logic [4:0]       ld_rd_i,
    input  logic             br_resolve_i,
    input  logic             br_taken_i,
    output logic             flush_o,
    output logic             illegal_o,
    output logic [31:0]      busy_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [3:0] LdMax = 4'(MAX_LD);

    instr_class_t dec_cls;
    logic [4:0]   dec_rs1, dec_rs2, dec_rd;
    logic         dec_use_rs1, dec_use_rs2;

    rv_opclass_decode u_decode (
        .instr   (in_instr_i),
        .cls     (dec_cls),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .rd      (dec_rd),
        .use_rs1 (dec_use_rs1),
        .use_rs2 (dec_use_rs2)
    );

    issue_state_t     state_q, state_d;
    logic             slot_valid_q;
    logic [31:0]      slot_instr_q;
    instr_class_t     slot_cls_q;
    logic [31:0]      busy_q, busy_d;
    logic [3:0]       ld_cnt_q, ld_cnt_d;
    logic             illegal_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic hazard, ld_full, ready, accept, ld_accept, is_ctrl;

    always_comb begin
        hazard    = (dec_use_rs1 && busy_q[dec_rs1]) || (dec_use_rs2 && busy_q[dec_rs2]);
        ld_full   = (dec_cls == C_IL) && (ld_cnt_q == LdMax);
        // RES_N term keeps in_ready_o low while reset is held.
        ready     = RES_N && (state_q == RUN) && (!slot_valid_q || iss_ready_i)
                    && !hazard && !ld_full;
        accept    = in_valid_i && ready;
        ld_accept = accept && (dec_cls == C_IL);
        is_ctrl   = (dec_cls == C_SB) || (dec_cls == C_J) || (dec_cls == C_JALR);
    end

    // Scoreboard and load counter; a load accepted in the same cycle as a
    // writeback to the same rd leaves the register busy.
    always_comb begin
        busy_d = busy_q;
        if (ld_done_i) busy_d[ld_rd_i] = 1'b0;
        if (ld_accept && dec_rd != 5'd0) busy_d[dec_rd] = 1'b1;
        busy_d[0] = 1'b0;

        ld_cnt_d = ld_cnt_q;
        if (ld_accept && !ld_done_i) begin
            ld_cnt_d = ld_cnt_q + 4'd1;
        end else if (!ld_accept && ld_done_i && ld_cnt_q != 4'd0) begin
            ld_cnt_d = ld_cnt_q - 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (accept && is_ctrl) state_d = BR_WAIT;
            BR_WAIT: if (br_resolve_i) state_d = br_taken_i ? FLUSH : RUN;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q      <= RUN;
            slot_valid_q <= 1'b0;
            slot_instr_q <= 32'd0;
            slot_cls_q   <= C_R;
            busy_q       <= 32'd0;
            ld_cnt_q     <= 4'd0;
            illegal_q    <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            ld_cnt_q  <= ld_cnt_d;
            illegal_q <= accept && (dec_cls == C_ILL);
            // Illegal instructions are consumed without occupying the slot.
            if (accept && dec_cls != C_ILL) begin
                slot_valid_q <= 1'b1;
                slot_instr_q <= in_instr_i;
                slot_cls_q   <= dec_cls;
            end else if (iss_ready_i) begin
                slot_valid_q <= 1'b0;
            end
            if (in_valid_i && !ready && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_ready_o  = ready;
    assign iss_valid_o = slot_valid_q;
    assign iss_instr_o = slot_instr_q;
    assign iss_class_o = slot_cls_q;
    assign flush_o     = (state_q == FLUSH);
    assign illegal_o   = illegal_q;
    assign busy_o      = busy_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_rv_issue_ctrl.sv
// Randomised scoreboard bench for rv_issue_ctrl. Accepted instructions are pushed
// into an expectation queue by the driver; a monitor pops and compares on every
// issue-slot handshake. Flow control, scoreboard and counters are predicted by a
// behavioural model built from the instruction-set rules.
module tb_rv_issue_ctrl;
    import rv_issue_ctrl_pkg::*;

    localparam int MaxLd = 4;
    localparam int CntW  = 16;

    logic            clk = 1'b0;
    logic            res_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_instr = 32'd0;
    logic            iss_valid;
    logic            iss_ready = 1'b0;
    logic [31:0]     iss_instr;
    instr_class_t    iss_class;
    logic            ld_done = 1'b0;
    logic [4:0]      ld_rd = 5'd0;
    logic            br_resolve = 1'b0;
    logic            br_taken = 1'b0;
    logic            flush;
    logic            illegal;
    logic [31:0]     busy;
    logic [CntW-1:0] stall_cnt;

    always #5 clk = ~clk;

    rv_issue_ctrl #(.MAX_LD(MaxLd), .CNT_W(CntW)) dut (
        .CLK          (clk),
        .RES_N        (res_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_instr_i   (in_instr),
        .iss_valid_o  (iss_valid),
        .iss_ready_i  (iss_ready),
        .iss_instr_o  (iss_instr),
        .iss_class_o  (iss_class),
        .ld_done_i    (ld_done),
        .ld_rd_i      (ld_rd),
        .br_resolve_i (br_resolve),
        .br_taken_i   (br_taken),
        .flush_o      (flush),
        .illegal_o    (illegal),
        .busy_o       (busy),
        .stall_cnt_o  (stall_cnt)
    );

    // Monitor re-decodes what the DUT issues, checked against the model's class.
    instr_class_t mon_cls;
    logic [4:0]   mon_rs1, mon_rs2, mon_rd;
    logic         mon_u1, mon_u2;
    rv_opclass_decode u_mon_dec (
        .instr   (iss_instr),
        .cls     (mon_cls),
        .rs1     (mon_rs1),
        .rs2     (mon_rs2),
        .rd      (mon_rd),
        .use_rs1 (mon_u1),
        .use_rs2 (mon_u2)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0]  instr;
        instr_class_t cls;
    } slot_t;
    slot_t exp_q[$];

    // Behavioural model state
    bit    m_busy[32];
    int    m_ld;
    int    m_mode;      // 0 = running, 1 = waiting for branch outcome, 2 = flushing
    int    m_stall;
    bit    m_illegal;
    bit    last_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic instr_class_t ref_class(input logic [31:0] ins);
        case (ins[6:0])
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0000011: return C_IL;
            7'b0100011: return C_S;
            7'b1100011: return C_SB;
            7'b1101111: return C_J;
            7'b1100111: return C_JALR;
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic logic [31:0] model_busy_word();
        logic [31:0] w;
        for (int i = 0; i < 32; i++) w[i] = m_busy[i];
        return w;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        logic [6:0]  op;
        w = $urandom;
        case ($urandom_range(0, 13))
            0, 1, 2, 3: op = 7'b0000011;      // loads weighted up to exercise the limit
            4, 5:       op = 7'b0110011;
            6:          op = 7'b0010011;
            7:          op = 7'b0100011;
            8:          op = 7'b1100011;
            9:          op = 7'b1101111;
            10:         op = 7'b1100111;
            11:         op = ($urandom_range(0, 1) == 0) ? 7'b0110111 : 7'b0010111;
            12:         op = 7'b1111111;
            default:    op = 7'b1110011;
        endcase
        w[6:0]   = op;
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_ld      = 0;
        m_mode    = 0;
        m_stall   = 0;
        m_illegal = 1'b0;
        last_acc  = 1'b0;
        exp_q.delete();
    endtask

    // One clock of random stimulus, checks, and model update.
    task automatic do_cycle(input int p_done);
        instr_class_t c;
        bit reads1, reads2, haz, exp_rdy, acc, ctrl;
        int rd;
        @(negedge clk);
        if (!(in_valid && !last_acc) || $urandom_range(0, 3) == 0) in_instr = gen_instr();
        in_valid   = ($urandom_range(0, 9) < 7);
        iss_ready  = ($urandom_range(0, 9) < 7);
        ld_done    = ($urandom_range(0, 99) < p_done);
        ld_rd      = 5'($urandom_range(0, 7));
        br_resolve = (m_mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
        br_taken   = $urandom_range(0, 1);
        #1;
        c      = ref_class(in_instr);
        reads1 = (c == C_R) || (c == C_S) || (c == C_SB) || (c == C_I) || (c == C_IL) ||
                 (c == C_JALR);
        reads2 = (c == C_R) || (c == C_S) || (c == C_SB);
        haz    = (reads1 && m_busy[in_instr[19:15]]) || (reads2 && m_busy[in_instr[24:20]]);
        exp_rdy = (m_mode == 0) && (exp_q.size() == 0 || iss_ready) && !haz &&
                  !(c == C_IL && m_ld == MaxLd);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("iss_valid", 32'(iss_valid), 32'(exp_q.size() != 0));
        check("busy", busy, model_busy_word());
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("flush", 32'(flush), 32'(m_mode == 2));
        check("illegal", 32'(illegal), 32'(m_illegal));
        @(posedge clk);
        acc  = in_valid && exp_rdy;
        ctrl = (c == C_SB) || (c == C_J) || (c == C_JALR);
        rd   = int'(in_instr[11:7]);
        if (in_valid && !exp_rdy && m_stall < 65535) m_stall++;
        if (acc && c != C_ILL) exp_q.push_back('{instr: in_instr, cls: c});
        m_illegal = acc && (c == C_ILL);
        if (acc && c == C_IL && !ld_done) m_ld++;
        else if (!(acc && c == C_IL) && ld_done && m_ld > 0) m_ld--;
        if (ld_done) m_busy[ld_rd] = 1'b0;
        if (acc && c == C_IL && rd != 0) m_busy[rd] = 1'b1;
        if (m_mode == 0 && acc && ctrl) m_mode = 1;
        else if (m_mode == 1 && br_resolve) m_mode = br_taken ? 2 : 0;
        else if (m_mode == 2) m_mode = 0;
        last_acc = acc;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 32'd0);
        check({tag, "_iss_valid"}, 32'(iss_valid), 32'd0);
        check({tag, "_stall"}, 32'(stall_cnt), 32'd0);
        check({tag, "_flush"}, 32'(flush), 32'd0);
        check({tag, "_illegal"}, 32'(illegal), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    // Asynchronous reset asserted between clock edges, mid-operation.
    task automatic mid_reset();
        @(negedge clk);
        #1;
        res_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("async_reset");
        in_valid   = 1'b0;
        ld_done    = 1'b0;
        br_resolve = 1'b0;
        repeat (2) @(negedge clk);
        res_n = 1'b1;
    endtask

    // Monitor: compare on every issue-slot handshake.
    initial begin
        slot_t e;
        forever begin
            @(negedge clk);
            #2;
            if (iss_valid && iss_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_issue at %0t: got %h, expected nothing", $time,
                             iss_instr);
                end else begin
                    e = exp_q.pop_front();
                    check("iss_instr", iss_instr, e.instr);
                    check("iss_class", 32'(iss_class), 32'(e.cls));
                    check("decode_class", 32'(mon_cls), 32'(e.cls));
                end
            end
        end
    end

    initial begin
        model_reset();
        #2;
        check_reset_outputs("reset");
        check("reset_iss_instr", iss_instr, 32'd0);
        check("reset_iss_class", 32'(iss_class), 32'd0);
        @(negedge clk);
        res_n = 1'b1;
        for (int i = 0; i < 400; i++) do_cycle(10);
        mid_reset();
        for (int i = 0; i < 400; i++) do_cycle(40);
        mid_reset();
        for (int i = 0; i < 300; i++) do_cycle(5);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
